// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational imem, queues {pc, instr} for decode.
// Latency: a word fetched in cycle N is at the queue head in cycle N+1; redirect costs one flush cycle.
// Backpressure: out_ready low fills the queue, then fetch stalls; a full queue pushes and pops in the same cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   run                      fetch enable (queue still drains when low)
//   imem_addr / imem_rdata   byte address (= PC) and the word returned for it in the same cycle
//   out_valid/out_ready      decode handshake; out_instr/out_pc are the head entry
//   redirect_valid/_pc       taken branch: flush queue, load PC (low two bits cleared)
//   fetch_done               PC has moved past the last fetchable word
//   count                    queue occupancy
module fetch_ctrl #(
    parameter logic [31:0] PC_RESET  = 32'd0,
    parameter int          MEM_WORDS = 16,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_done,
    output logic [2:0]  count
);

    localparam int          PW       = (DEPTH == 4) ? 2 : 1;
    localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;
    localparam logic [31:0] PC_INIT  = PC_RESET & 32'hFFFF_FFFC;

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0]    count_q, count_d;
    logic [31:0]   q_pc_q    [DEPTH];
    logic [31:0]   q_instr_q [DEPTH];

    logic pop;
    logic push;

    // Done is purely a function of the PC, so reset and redirect both update it for free.
    // The 33-bit compare keeps addresses near 2^32 from aliasing below the limit.
    assign fetch_done = ({1'b0, pc_q} >= PC_LIMIT);
    assign imem_addr  = pc_q;
    assign out_valid  = (count_q != 3'd0);
    assign out_instr  = q_instr_q[rd_ptr_q];
    assign out_pc     = q_pc_q[rd_ptr_q];
    assign count      = count_q;

    assign pop  = out_valid && out_ready;
    // The pop term lets a full queue keep streaming at one word per cycle.
    assign push = run && !fetch_done && !redirect_valid &&
                  ((count_q < 3'(DEPTH)) || pop);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            // Flush by collapsing the read pointer onto the write pointer; a
            // concurrent pop is simply absorbed by the flush.
            pc_d     = redirect_pc & 32'hFFFF_FFFC;
            rd_ptr_d = wr_ptr_q;
            count_d  = 3'd0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= PC_INIT;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= 3'd0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_q[i]    <= 32'd0;
                q_instr_q[i] <= 32'd0;
            end
        end else if (push) begin
            q_pc_q[wr_ptr_q]    <= pc_q;
            q_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_done;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    // Expected PCs in delivery order; the instruction is derived from the PC.
    logic [31:0] sb [$];

    // run pattern 1,0,0,1 then a trailing 0 to drain the last word
    logic        run_pat5  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp_addr5 [5] = '{32'd12, 32'd12, 32'd12, 32'd16, 32'd16};
    logic [31:0] exp_cnt5  [5] = '{32'd2, 32'd1, 32'd0, 32'd1, 32'd0};

    fetch_ctrl #(.PC_RESET(32'd0), .MEM_WORDS(16), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_done     (fetch_done),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {16'hA5C3, a[15:0]} ^ 32'h0000_1111;
    endfunction

    // Instruction memory model: 16 words, out-of-range reads return a marker.
    assign imem_rdata = (imem_addr < 32'd64) ? word_of(imem_addr) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called with inputs stable, before the rising edge; scores the handshake
    // that edge will complete.
    task automatic handshake_check();
        logic [31:0] epc;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL sb_underflow: observed pc %h expected no delivery", out_pc);
        end
        if (sb.size() != 0) begin
            epc = sb.pop_front();
            check("hs_pc", out_pc, epc);
            check("hs_instr", out_instr, word_of(epc));
        end
    endtask

    // One clock: score the handshake, then return at the next falling edge.
    task automatic clk_step();
        #1;
        if (out_valid && out_ready) handshake_check();
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_count"}, {29'd0, count}, 32'd0);
        check({tag, "_addr"}, imem_addr, 32'd0);
        check({tag, "_done"}, {31'd0, fetch_done}, 32'd0);
        check({tag, "_instr"}, out_instr, 32'd0);
        check({tag, "_pc"}, out_pc, 32'd0);
    endtask

    task automatic do_reset();
        run            = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        rst            = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check_reset_state("rst");
    endtask

    initial begin
        rst            = 1'b1;
        run            = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // 1: streaming, one word per cycle, no bubbles
        do_reset();
        run = 1'b1; out_ready = 1'b1;
        sb.push_back(32'd0); sb.push_back(32'd4); sb.push_back(32'd8); sb.push_back(32'd12);
        clk_step();
        check("s1_first_valid", {31'd0, out_valid}, 32'd1);
        check("s1_first_pc", out_pc, 32'd0);
        for (int i = 0; i < 4; i++) begin
            clk_step();
            check("s1_no_bubble", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b0; run = 1'b0;
        check("s1_drain", sb.size(), 32'd0);

        // 2: backpressure saturates the queue, then release delivers in order
        do_reset();
        run = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            clk_step();
            check("s2_count", {29'd0, count}, (i < 2) ? 32'(i) : 32'd2);
        end
        check("s2_addr", imem_addr, 32'd8);
        check("s2_head_pc", out_pc, 32'd0);
        check("s2_head_instr", out_instr, word_of(32'd0));
        sb.push_back(32'd0); sb.push_back(32'd4); sb.push_back(32'd8);
        out_ready = 1'b1;
        repeat (3) clk_step();
        check("s2_full_stream_count", {29'd0, count}, 32'd2);
        out_ready = 1'b0; run = 1'b0;
        check("s2_drain", sb.size(), 32'd0);

        // 3: redirect on a full queue, with the head popped on the same edge
        do_reset();
        run = 1'b1;
        repeat (2) clk_step();
        check("s3_full", {29'd0, count}, 32'd2);
        sb.push_back(32'd0);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_000E;
        clk_step();
        redirect_valid = 1'b0;
        check("s3_flush_valid", {31'd0, out_valid}, 32'd0);
        check("s3_flush_count", {29'd0, count}, 32'd0);
        check("s3_target", imem_addr, 32'h0000_000C);
        sb.push_back(32'h0C); sb.push_back(32'h10);
        clk_step();
        check("s3_new_head", out_pc, 32'h0000_000C);
        repeat (2) clk_step();
        out_ready = 1'b0; run = 1'b0;
        check("s3_drain", sb.size(), 32'd0);

        // 4: run off the end of memory, drain, then redirect back in range
        do_reset();
        run = 1'b1; out_ready = 1'b1;
        for (int a = 0; a < 64; a += 4) sb.push_back(32'(a));
        repeat (16) clk_step();
        check("s4_done", {31'd0, fetch_done}, 32'd1);
        check("s4_pc_end", imem_addr, 32'd64);
        check("s4_last_pc", out_pc, 32'd60);
        clk_step();
        check("s4_empty", {29'd0, count}, 32'd0);
        clk_step();
        check("s4_no_push", imem_addr, 32'd64);
        check("s4_idle_count", {29'd0, count}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        clk_step();
        redirect_valid = 1'b0;
        check("s4_done_clr", {31'd0, fetch_done}, 32'd0);
        check("s4_resume", imem_addr, 32'h20);
        sb.push_back(32'h20);
        clk_step();
        check("s4_resume_head", out_pc, 32'h20);
        clk_step();
        out_ready = 1'b0; run = 1'b0;
        check("s4_drain", sb.size(), 32'd0);

        // 5: run toggling; queued entries still pop while run is low
        do_reset();
        run = 1'b1;
        repeat (2) clk_step();
        sb.push_back(32'd0); sb.push_back(32'd4); sb.push_back(32'd8); sb.push_back(32'd12);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run = run_pat5[i];
            clk_step();
            check("s5_addr", imem_addr, exp_addr5[i]);
            check("s5_count", {29'd0, count}, exp_cnt5[i]);
        end
        out_ready = 1'b0; run = 1'b0;
        check("s5_drain", sb.size(), 32'd0);

        // 6: asynchronous reset mid-stream
        do_reset();
        run = 1'b1;
        repeat (2) clk_step();
        check("s6_pre_count", {29'd0, count}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("s6_async_valid", {31'd0, out_valid}, 32'd0);
        check("s6_async_count", {29'd0, count}, 32'd0);
        check("s6_async_addr", imem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        run = 1'b1; out_ready = 1'b1;
        sb.push_back(32'd0);
        clk_step();
        check("s6_restart_pc", out_pc, 32'd0);
        clk_step();
        out_ready = 1'b0; run = 1'b0;
        check("s6_drain", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
